ext_pipe: RTL and testbench

- Parametrised, pipelined extension unit. Replaces the single-cycle combinational immediate extender.
- Covers immediate extension (zero, sign, load-upper, branch offset <<2) and load-data extension (lb/lbu/lh/lhu with byte-offset selection).
- Sits between decode/memory stages and consumers.
- Results pass through DEPTH register stages with valid/ready back-pressure and a synchronous flush.

---
 rtl/ext_pkg.sv | 54 +++++
 rtl/ext_pipe_stage.sv | 42 ++++
 rtl/ext_pipe.sv | 66 ++++++
 tb/tb_ext_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Mode encodings and the shared extension function for the ext_pipe unit.
// The function works at EXT_MAX_W bits; callers pass their own widths and keep the low bits.
package ext_pkg;

  localparam logic [2:0] EXT_ZERO   = 3'd0;
  localparam logic [2:0] EXT_SIGN   = 3'd1;
  localparam logic [2:0] EXT_UPPER  = 3'd2;
  localparam logic [2:0] EXT_BRANCH = 3'd3;
  localparam logic [2:0] EXT_LB     = 3'd4;
  localparam logic [2:0] EXT_LBU    = 3'd5;
  localparam logic [2:0] EXT_LH     = 3'd6;
  localparam logic [2:0] EXT_LHU    = 3'd7;

  localparam int EXT_MAX_W = 64;

  // Returns {err, result}; result is already masked to data_w bits.
  function automatic logic [EXT_MAX_W:0] ext_compute(
    input logic [2:0]           mode,
    input logic [EXT_MAX_W-1:0] data,
    input logic [1:0]           off,
    input int                   imm_w,
    input int                   data_w
  );
    logic [EXT_MAX_W-1:0] dmask, imask, imm, simm;
    logic [EXT_MAX_W-1:0] byt_u, byt_s, half_u, half_s, res;
    logic                 err;
    dmask  = (data_w >= EXT_MAX_W) ? '1 : ((64'd1 << data_w) - 64'd1);
    imask  = (64'd1 << imm_w) - 64'd1;
    imm    = data & imask;
    simm   = (|(data & (64'd1 << (imm_w - 1)))) ? (imm | ~imask) : imm;
    byt_u  = (data >> {off, 3'b000}) & 64'hFF;
    byt_s  = byt_u[7] ? (byt_u | ~64'hFF) : byt_u;
    half_u = (data >> {off[1], 4'b0000}) & 64'hFFFF;
    half_s = half_u[15] ? (half_u | ~64'hFFFF) : half_u;
    err    = 1'b0;
    case (mode)
      EXT_ZERO:   res = imm;
      EXT_SIGN:   res = simm;
      EXT_UPPER:  res = imm << (data_w - imm_w);
      EXT_BRANCH: res = simm << 2;
      EXT_LB:     res = byt_s;
      EXT_LBU:    res = byt_u;
      EXT_LH:     res = half_s;
      EXT_LHU:    res = half_u;
      default:    res = '0;
    endcase
    if ((mode == EXT_LH || mode == EXT_LHU) && off[0]) begin
      err = 1'b1;
      res = '0;
    end
    return {err, res & dmask};
  endfunction

endpackage

// File: rtl/ext_pipe_stage.sv
// One valid/ready register stage carrying {valid, data, err}; 1 cycle latency.
// Loads whenever empty or downstream ready, so it never drops or duplicates; flush clears valid only.
module ext_pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_err,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_err
);

  logic              r_vld;
  logic [DATA_W-1:0] r_dat;
  logic              r_err;

  assign up_ready = !r_vld || dn_ready;
  assign dn_valid = r_vld;
  assign dn_data  = r_dat;
  assign dn_err   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_err <= 1'b0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (up_ready) begin
      r_vld <= up_valid;
      r_dat <= up_data;
      r_err <= up_err;
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate/load-data extender: result computed at the input, then DEPTH handshake stages.
// Latency DEPTH cycles, 1/cycle throughput; in_ready drops only when every stage holds a result.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [EXT_MAX_W:0] w_calc;
  logic [DEPTH:0]     w_vld;
  logic [DEPTH:0]     w_rdy;
  logic [DEPTH:0]     w_err;
  logic [DATA_W-1:0]  w_dat [DEPTH+1];

  assign w_calc   = ext_compute(in_mode, EXT_MAX_W'(in_data), in_off, IMM_W, DATA_W);

  // Index 0 is the combinational input side; index DEPTH is the output side.
  assign w_vld[0] = in_valid && !flush;
  assign w_dat[0] = w_calc[DATA_W-1:0];
  assign w_err[0] = w_calc[EXT_MAX_W];
  assign w_rdy[DEPTH] = out_ready;

  generate
    if (DATA_W < EXT_MAX_W) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_calc[EXT_MAX_W-1:DATA_W];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      ext_pipe_stage #(.DATA_W(DATA_W)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .up_valid (w_vld[k]),
        .up_ready (w_rdy[k]),
        .up_data  (w_dat[k]),
        .up_err   (w_err[k]),
        .dn_valid (w_vld[k+1]),
        .dn_ready (w_rdy[k+1]),
        .dn_data  (w_dat[k+1]),
        .dn_err   (w_err[k+1])
      );
    end
  endgenerate

  assign in_ready  = w_rdy[0] && !flush;
  assign out_valid = w_vld[DEPTH];
  assign out_data  = w_dat[DEPTH];
  assign out_err   = w_err[DEPTH];

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: DEPTH 1/2/4 instances share inputs; DEPTH=2 carries the handshake scenarios.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_data;
  logic [1:0]  in_off;

  logic        o1_ir, o1_valid, o1_err;
  logic        o2_ir, o2_valid, o2_err;
  logic        o4_ir, o4_valid, o4_err;
  logic [31:0] o1_data, o2_data, o4_data;

  int n_tot = 0;
  int n_bad = 0;

  logic [2:0]  v_mode [8];
  logic [31:0] v_data [8];
  logic [1:0]  v_off  [8];
  logic [31:0] e_dat  [8];
  logic        e_err  [8];

  always #5 clk = ~clk;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(1)) d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o1_ir),
    .in_mode(in_mode), .in_data(in_data), .in_off(in_off), .out_valid(o1_valid),
    .out_ready(out_ready), .out_data(o1_data), .out_err(o1_err));

  ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(2)) d2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o2_ir),
    .in_mode(in_mode), .in_data(in_data), .in_off(in_off), .out_valid(o2_valid),
    .out_ready(out_ready), .out_data(o2_data), .out_err(o2_err));

  ext_pipe #(.IMM_W(16), .DATA_W(32), .DEPTH(4)) d4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o4_ir),
    .in_mode(in_mode), .in_data(in_data), .in_off(in_off), .out_valid(o4_valid),
    .out_ready(out_ready), .out_data(o4_data), .out_err(o4_err));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [2:0] m, input logic [31:0] d,
                         input logic [1:0] o, input logic [31:0] ed, input logic ee);
    v_mode[i] = m; v_data[i] = d; v_off[i] = o; e_dat[i] = ed; e_err[i] = ee;
  endtask

  task automatic check_lane(input string nm, input int d, input int s, input int n,
                            input logic v, input logic [31:0] dat, input logic err);
    int idx;
    idx = s - d;
    if (idx >= 0 && idx < n) begin
      chk($sformatf("%s d%0d s%0d vld", nm, d, s), 64'(v), 64'd1);
      chk($sformatf("%s d%0d s%0d dat", nm, d, s), 64'(dat), 64'(e_dat[idx]));
      chk($sformatf("%s d%0d s%0d err", nm, d, s), 64'(err), 64'(e_err[idx]));
    end else begin
      chk($sformatf("%s d%0d s%0d idle", nm, d, s), 64'(v), 64'd0);
    end
  endtask

  // Back-to-back stream of n vectors with out_ready high; every instance checked each slot.
  task automatic run_stream(input int n, input string nm);
    for (int s = 0; s < n + 5; s++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (s < n) begin
        in_valid = 1'b1; in_mode = v_mode[s]; in_data = v_data[s]; in_off = v_off[s];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("%s s%0d in_ready", nm, s), 64'(o2_ir), 64'd1);
      check_lane(nm, 1, s, n, o1_valid, o1_data, o1_err);
      check_lane(nm, 2, s, n, o2_valid, o2_data, o2_err);
      check_lane(nm, 4, s, n, o4_valid, o4_data, o4_err);
    end
  endtask

  task automatic idle_slots(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    end
  endtask

  // Stall scenario timeline for DEPTH=2: A..D are 32'hA0..A3 in ZERO mode.
  logic       st_iv  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int         st_idx [10] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
  logic       st_or  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  logic       st_ir  [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic       st_ov  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int         st_od  [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 3'd0; in_data = '0; in_off = 2'd0;
    #12;
    chk("rst out_valid", 64'(o2_valid), 64'd0);
    chk("rst out_data",  64'(o2_data),  64'd0);
    chk("rst out_err",   64'(o2_err),   64'd0);
    chk("rst in_ready",  64'(o2_ir),    64'd1);
    @(negedge clk);
    reset = 1'b1;

    // Immediate modes on FFF8; upper input bits must be ignored.
    set_vec(0, 3'd0, 32'h1234FFF8, 2'd0, 32'h0000FFF8, 1'b0);
    set_vec(1, 3'd1, 32'h1234FFF8, 2'd0, 32'hFFFFFFF8, 1'b0);
    set_vec(2, 3'd2, 32'h1234FFF8, 2'd0, 32'hFFF80000, 1'b0);
    set_vec(3, 3'd3, 32'h1234FFF8, 2'd0, 32'hFFFFFFE0, 1'b0);
    run_stream(4, "imm");

    // Load modes on 8899AABB.
    set_vec(0, 3'd4, 32'h8899AABB, 2'd2, 32'hFFFFFF99, 1'b0);
    set_vec(1, 3'd5, 32'h8899AABB, 2'd2, 32'h00000099, 1'b0);
    set_vec(2, 3'd6, 32'h8899AABB, 2'd1, 32'h00000000, 1'b1);
    set_vec(3, 3'd6, 32'h8899AABB, 2'd2, 32'hFFFF8899, 1'b0);
    set_vec(4, 3'd7, 32'h8899AABB, 2'd2, 32'h00008899, 1'b0);
    set_vec(5, 3'd4, 32'h8899AABB, 2'd0, 32'hFFFFFFBB, 1'b0);
    set_vec(6, 3'd7, 32'h8899AABB, 2'd3, 32'h00000000, 1'b1);
    set_vec(7, 3'd7, 32'h8899AABB, 2'd0, 32'h0000AABB, 1'b0);
    run_stream(8, "load");

    // Stall with out_ready low for slots 0-4.
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      in_valid  = st_iv[s];
      in_mode   = 3'd0;
      in_off    = 2'd0;
      in_data   = 32'hA0 + 32'(st_idx[s]);
      out_ready = st_or[s];
      #1;
      chk($sformatf("stall s%0d in_ready", s), 64'(o2_ir), 64'(st_ir[s]));
      chk($sformatf("stall s%0d out_valid", s), 64'(o2_valid), 64'(st_ov[s]));
      if (st_ov[s])
        chk($sformatf("stall s%0d out_data", s), 64'(o2_data), 64'h0A0 + 64'(st_od[s]));
    end
    idle_slots(6);

    // Fill DEPTH=2 with out_ready low, then flush with in_valid high and out_ready high.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0; in_data = 32'hE0;
    @(posedge clk); #1;
    in_data = 32'hE1;
    @(posedge clk); #1;
    flush = 1'b1; in_data = 32'hEE; out_ready = 1'b1;
    #1;
    chk("flush in_ready", 64'(o2_ir), 64'd0);
    chk("flush out_valid", 64'(o2_valid), 64'd1);
    chk("flush out_data", 64'(o2_data), 64'hE0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("post flush out_valid", 64'(o2_valid), 64'd0);
    chk("post flush in_ready", 64'(o2_ir), 64'd1);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #2;
      chk($sformatf("post flush s%0d d2 vld", s), 64'(o2_valid), 64'd0);
      chk($sformatf("post flush s%0d d4 vld", s), 64'(o4_valid), 64'd0);
    end

    // Async reset with two results in flight.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 3'd0; in_data = 32'h55;
    @(posedge clk); #1;
    in_mode = 3'd6; in_off = 2'd1; in_data = 32'h66;
    @(posedge clk); #1;
    in_valid = 1'b0; in_off = 2'd0;
    #1;
    chk("pre rst out_valid", 64'(o2_valid), 64'd1);
    chk("pre rst out_data", 64'(o2_data), 64'h55);
    reset = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(o2_valid), 64'd0);
    chk("mid rst out_data", 64'(o2_data), 64'd0);
    chk("mid rst out_err", 64'(o2_err), 64'd0);
    chk("mid rst in_ready", 64'(o2_ir), 64'd1);
    #1;
    reset = 1'b1;
    set_vec(0, 3'd1, 32'h00008001, 2'd0, 32'hFFFF8001, 1'b0);
    run_stream(1, "after rst");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
